// File: rtl/video_pkg.sv
// Shared types and defaults for the camera-to-stream packetizer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package video_pkg;

  localparam int IMG_WIDTH_DEF  = 320;
  localparam int IMG_LENGTH_DEF = 240;

  typedef logic [11:0] pixel_t;
  typedef logic [2:0]  kernel_sel_t;

  typedef struct packed {
    pixel_t data;
    logic   sop;
    logic   eop;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } pkt_state_t;

  // Counter width for a range of n values; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_packetizer_if.sv
// Camera input, Avalon-ST output and status bundle of the packetizer.
// Latency: n/a (wiring only).
// Backpressure: ready_in from the sink; the camera side has none.
interface video_packetizer_if;
  import video_pkg::*;

  logic        frame_start;
  logic        pixel_valid;
  pixel_t      pixel_data;
  kernel_sel_t freq_flag_in;
  logic        ready_in;
`ifdef VIDEO_PACKETIZER_PATTERN_EN
  logic        pattern_sel;
`endif

  logic        valid_out;
  logic        startofpacket_out;
  logic        endofpacket_out;
  pixel_t      data_out;
  kernel_sel_t freq_flag_out;
  logic        overflow;

  // Camera plus downstream sink: drives pixels and ready, observes the stream.
  modport master (
`ifdef VIDEO_PACKETIZER_PATTERN_EN
    output pattern_sel,
`endif
    output frame_start, pixel_valid, pixel_data, freq_flag_in, ready_in,
    input  valid_out, startofpacket_out, endofpacket_out, data_out,
    input  freq_flag_out, overflow
  );

  // Packetizer side.
  modport slave (
`ifdef VIDEO_PACKETIZER_PATTERN_EN
    input  pattern_sel,
`endif
    input  frame_start, pixel_valid, pixel_data, freq_flag_in, ready_in,
    output valid_out, startofpacket_out, endofpacket_out, data_out,
    output freq_flag_out, overflow
  );

endinterface

// File: rtl/stream_fifo.sv
// Small circular buffer of stream beats with full/empty flags.
// Latency: a write at edge N is visible on o_rd_dat right after edge N.
// Backpressure: a write when full is dropped unless a read happens in the same cycle.
module stream_fifo
  import video_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = beat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wr_vld,
  input  T     i_wr_dat,
  output logic o_full,
  input  logic i_rd_rdy,
  output logic o_rd_vld,
  output T     o_rd_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_rd;
  logic           w_wr;

  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_rd_vld = (r_count != '0);
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign w_rd     = o_rd_vld && i_rd_rdy;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign w_wr     = i_wr_vld && (!o_full || w_rd);

  // Storage array; contents are only meaningful below r_count, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/video_packetizer.sv
// Packs camera pixels into one Avalon-ST packet per frame; optional test pattern via VIDEO_PACKETIZER_PATTERN_EN.
// Latency: 1 cycle from pixel write to data_out when the buffer is empty.
// Backpressure: camera cannot stall; pixels arriving with a full, unread buffer are dropped and flag overflow.
module video_packetizer
  import video_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_LENGTH = IMG_LENGTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  video_packetizer_if.slave vif
);

  localparam int XW = cnt_width(IMG_WIDTH);
  localparam int YW = cnt_width(IMG_LENGTH);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_LENGTH - 1);

  pkt_state_t    r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  kernel_sel_t   r_pending;
  kernel_sel_t   r_freq;
  logic          r_overflow;

  logic [XW-1:0] w_cur_x;
  logic [YW-1:0] w_cur_y;
  logic          w_accept;
  logic          w_sop;
  logic          w_eop;
  pixel_t        w_pixel;
  beat_t         w_beat;
  beat_t         w_head;
  logic          w_head_vld;
  logic          w_full;
  logic          w_rd;
  logic          w_drop;

  // A frame_start pixel is always coordinate (0,0), whatever the counters held.
  assign w_cur_x  = vif.frame_start ? '0 : r_x;
  assign w_cur_y  = vif.frame_start ? '0 : r_y;
  assign w_accept = vif.pixel_valid && (vif.frame_start || (r_state == ST_ACTIVE));
  assign w_sop    = (w_cur_x == '0) && (w_cur_y == '0);
  assign w_eop    = (w_cur_x == X_LAST) && (w_cur_y == Y_LAST);

`ifdef VIDEO_PACKETIZER_PATTERN_EN
  assign w_pixel = vif.pattern_sel ? {4'(w_cur_x), 4'(w_cur_y), 4'h0} : vif.pixel_data;
`else
  assign w_pixel = vif.pixel_data;
`endif

  assign w_beat = '{data: w_pixel, sop: w_sop, eop: w_eop};
  assign w_rd   = w_head_vld && vif.ready_in;
  assign w_drop = w_accept && w_full && !w_rd;

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (beat_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .i_wr_vld (w_accept),
    .i_wr_dat (w_beat),
    .o_full   (w_full),
    .i_rd_rdy (vif.ready_in),
    .o_rd_vld (w_head_vld),
    .o_rd_dat (w_head)
  );

  // Frame FSM and pixel coordinates; counters advance even when the pixel is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else if (w_accept) begin
      if (w_eop) begin
        r_state <= ST_DONE;
        r_x     <= '0;
        r_y     <= '0;
      end else if (w_cur_x == X_LAST) begin
        r_state <= ST_ACTIVE;
        r_x     <= '0;
        r_y     <= w_cur_y + YW'(1);
      end else begin
        r_state <= ST_ACTIVE;
        r_x     <= w_cur_x + XW'(1);
        r_y     <= w_cur_y;
      end
    end else if (vif.frame_start) begin
      r_state <= ST_ACTIVE;
      r_x     <= '0;
      r_y     <= '0;
    end
  end

  // Kernel selection: captured at frame_start, published when the sop beat leaves.
  // Overflow: a drop in the frame_start cycle belongs to the new frame, so it wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending  <= '0;
      r_freq     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (vif.frame_start) r_pending <= vif.freq_flag_in;
      if (w_rd && w_head.sop) r_freq <= r_pending;
      if (w_drop) r_overflow <= 1'b1;
      else if (vif.frame_start) r_overflow <= 1'b0;
    end
  end

  assign vif.valid_out         = w_head_vld;
  assign vif.data_out          = w_head_vld ? w_head.data : '0;
  assign vif.startofpacket_out = w_head_vld && w_head.sop;
  assign vif.endofpacket_out   = w_head_vld && w_head.eop;
  assign vif.freq_flag_out     = r_freq;
  assign vif.overflow          = r_overflow;

endmodule

// File: tb/tb_video_packetizer.sv
// Self-checking bench for video_packetizer using a queue-based frame model.
// Latency: n/a.
// Backpressure: ready_in driven randomly and in fixed stall windows.
module tb_video_packetizer;

  localparam int W = 20;
  localparam int L = 12;
  localparam int N = W * L;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  video_packetizer_if vif();

  video_packetizer #(
    .IMG_WIDTH  (W),
    .IMG_LENGTH (L),
    .FIFO_DEPTH (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  typedef struct {
    logic [11:0] data;
    logic        sop;
    logic        eop;
  } mbeat_t;

  typedef struct {
    bit          fs;
    bit          pv;
    logic [11:0] pd;
    bit          rdy;
    bit          e_vld;
    logic [11:0] e_dat;
    bit          e_sop;
    bit          e_eop;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame model: position in frame, pending/published kernel, sticky overflow, buffered beats.
  mbeat_t      mq[$];
  bit          m_in_frame;
  int          m_idx;
  logic [2:0]  m_pend;
  logic [2:0]  m_fo;
  bit          m_ovf;
  bit          pat = 1'b0;

  mbeat_t      seen[$];
  vec_t        tbl[6];
  logic [11:0] pix;
  logic [11:0] first_pix;
  int          nsop, neop, sop_at, eop_at, ovf_first;

`ifdef VIDEO_PACKETIZER_PATTERN_EN
  assign vif.pattern_sel = pat;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {13'b0, vif.valid_out, vif.data_out, vif.startofpacket_out,
            vif.endofpacket_out, vif.freq_flag_out, vif.overflow};
  endfunction

  function automatic logic [31:0] exp_outs();
    bit v = (mq.size() > 0);
    return {13'b0, v, v ? mq[0].data : 12'h000, v ? mq[0].sop : 1'b0,
            v ? mq[0].eop : 1'b0, m_fo, m_ovf};
  endfunction

  task automatic reset_model();
    mq.delete();
    m_in_frame = 1'b0;
    m_idx      = 0;
    m_pend     = 3'b000;
    m_fo       = 3'b000;
    m_ovf      = 1'b0;
  endtask

  task automatic model_update(input bit fs, input bit pv, input logic [11:0] pd,
                              input logic [2:0] ff, input bit rdy);
    mbeat_t b;
    int x, y;
    if (mq.size() > 0 && rdy) begin
      if (mq[0].sop) m_fo = m_pend;
      void'(mq.pop_front());
    end
    if (fs) begin
      m_in_frame = 1'b1;
      m_idx      = 0;
      m_pend     = ff;
      m_ovf      = 1'b0;
    end
    if (pv && m_in_frame) begin
      x = m_idx % W;
      y = m_idx / W;
      b.data = pat ? 12'((x % 16) * 256 + (y % 16) * 16) : pd;
      b.sop  = (m_idx == 0);
      b.eop  = (m_idx == N - 1);
      if (mq.size() < D) mq.push_back(b);
      else m_ovf = 1'b1;
      m_idx++;
      if (m_idx == N) m_in_frame = 1'b0;
    end
  endtask

  // One clock: entered just after a negedge, leaves just after the next negedge.
  task automatic step(input bit fs, input bit pv, input logic [11:0] pd,
                      input logic [2:0] ff, input bit rdy);
    mbeat_t t;
    vif.frame_start  = fs;
    vif.pixel_valid  = pv;
    vif.pixel_data   = pd;
    vif.freq_flag_in = ff;
    vif.ready_in     = rdy;
    if (vif.valid_out && rdy) begin
      t.data = vif.data_out;
      t.sop  = vif.startofpacket_out;
      t.eop  = vif.endofpacket_out;
      seen.push_back(t);
    end
    @(posedge clk);
    model_update(fs, pv, pd, ff, rdy);
    #1;
    check("cycle", outs(), exp_outs());
    @(negedge clk);
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 12'h000, 3'b000, 1'b1);
  endtask

  task automatic analyze();
    nsop = 0; neop = 0; sop_at = -1; eop_at = -1;
    for (int i = 0; i < seen.size(); i++) begin
      if (seen[i].sop) begin nsop++; if (sop_at < 0) sop_at = i; end
      if (seen[i].eop) begin neop++; if (eop_at < 0) eop_at = i; end
    end
  endtask

  initial begin
    logic [11:0] sent[$];
    int derr;
    int budget;
    bit fs;

    reset = 1'b1;
    vif.frame_start = 1'b0; vif.pixel_valid = 1'b0; vif.pixel_data = '0;
    vif.freq_flag_in = '0;  vif.ready_in = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    check("reset_state", outs(), 32'd0);
    reset = 1'b0;

    // Short directed table: IDLE ignore, sop with stall, hold, transfer, empty, 1-cycle latency.
    tbl[0] = '{0, 1, 12'hABC, 1, 0, 12'h000, 0, 0};
    tbl[1] = '{1, 1, 12'h111, 0, 1, 12'h111, 1, 0};
    tbl[2] = '{0, 1, 12'h222, 0, 1, 12'h111, 1, 0};
    tbl[3] = '{0, 0, 12'h000, 1, 1, 12'h222, 0, 0};
    tbl[4] = '{0, 0, 12'h000, 1, 0, 12'h000, 0, 0};
    tbl[5] = '{0, 1, 12'h333, 1, 1, 12'h333, 0, 0};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].fs, tbl[i].pv, tbl[i].pd, 3'b000, tbl[i].rdy);
      check($sformatf("vec%0d", i),
            {17'b0, vif.valid_out, vif.data_out, vif.startofpacket_out, vif.endofpacket_out},
            {17'b0, tbl[i].e_vld, tbl[i].e_dat, tbl[i].e_sop, tbl[i].e_eop});
    end
    drain(D + 2);

    // Full frame, no backpressure, frame_start coincident with the first pixel.
    seen.delete(); sent.delete();
    for (int i = 0; i < N; i++) begin
      pix = 12'($urandom_range(0, 4095));
      sent.push_back(pix);
      step(i == 0, 1'b1, pix, 3'b000, 1'b1);
    end
    drain(D + 2);
    analyze();
    derr = 0;
    for (int i = 0; i < seen.size() && i < N; i++) if (seen[i].data !== sent[i]) derr++;
    check("full_beats", seen.size(), N);
    check("full_sop_cnt", nsop, 1);
    check("full_sop_at", sop_at, 0);
    check("full_eop_cnt", neop, 1);
    check("full_eop_at", eop_at, N - 1);
    check("full_data_err", derr, 0);

    // Stall window 10..20: buffer fills by pixel 12, pixels 13..20 are dropped.
    seen.delete(); ovf_first = -1;
    for (int i = 0; i < N; i++) begin
      step(i == 0, 1'b1, 12'($urandom_range(0, 4095)), 3'b000, !(i >= 10 && i <= 20));
      if (vif.overflow && ovf_first < 0) ovf_first = i;
    end
    check("ovf_sticky", vif.overflow, 1);
    drain(D + 2);
    analyze();
    check("ovf_first", ovf_first, 13);
    check("ovf_beats", seen.size(), N - 8);
    check("ovf_eop_cnt", neop, 1);
    check("ovf_eop_last", seen.size() > 0 ? seen[seen.size()-1].eop : 1'b0, 1);

    // Kernel selection is frame-stable and switches only at the next sop transfer.
    for (int i = 0; i < N; i++)
      step(i == 0, 1'b1, 12'($urandom_range(0, 4095)), (i < 50) ? 3'b010 : 3'b001, 1'b1);
    drain(D + 2);
    check("kern_hold", vif.freq_flag_out, 3'b010);
    step(1'b1, 1'b1, 12'h5A5, 3'b001, 1'b1);
    check("kern_before_sop", vif.freq_flag_out, 3'b010);
    step(1'b0, 1'b1, 12'h5A6, 3'b001, 1'b1);
    check("kern_after_sop", vif.freq_flag_out, 3'b001);
    drain(D + 2);

    // Truncation: frame_start after 100 pixels restarts the packet.
    seen.delete();
    for (int i = 0; i < 100; i++) step(i == 0, 1'b1, 12'($urandom_range(0, 4095)), 3'b000, 1'b1);
    first_pix = 12'h7E1;
    step(1'b1, 1'b1, first_pix, 3'b000, 1'b1);
    for (int i = 1; i < N; i++) step(1'b0, 1'b1, 12'($urandom_range(0, 4095)), 3'b000, 1'b1);
    drain(D + 2);
    analyze();
    check("trunc_beats", seen.size(), 100 + N);
    check("trunc_sop101", seen.size() > 100 ? seen[100].sop : 1'b0, 1);
    check("trunc_data101", seen.size() > 100 ? seen[100].data : 12'h000, first_pix);
    check("trunc_eop_at", eop_at, 100 + N - 1);
    check("trunc_sop_cnt", nsop, 2);

    // Extra pixels after eop are ignored; then async reset with beats buffered.
    seen.delete();
    for (int i = 0; i < N + 5; i++) step(i == 0, 1'b1, 12'($urandom_range(0, 4095)), 3'b000, 1'b1);
    drain(D + 2);
    analyze();
    check("extra_beats", seen.size(), N);
    check("extra_eop_at", eop_at, N - 1);
    for (int i = 0; i < 3; i++) step(i == 0, 1'b1, 12'hF00 + 12'(i), 3'b110, 1'b0);
    check("pre_reset_vld", vif.valid_out, 1);
    vif.pixel_valid = 1'b0; vif.frame_start = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check("async_reset_outs", outs(), 32'd0);
    reset_model();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 12'h0F0, 3'b000, 1'b1);
    check("no_resume_wo_fs", vif.valid_out, 0);
    step(1'b1, 1'b1, 12'h0F1, 3'b011, 1'b1);
    check("resume_sop", {vif.valid_out, vif.startofpacket_out, vif.data_out}, {2'b11, 12'h0F1});

`ifdef VIDEO_PACKETIZER_PATTERN_EN
    // Test pattern replaces pixel data with coordinates.
    drain(D + 2);
    seen.delete();
    pat = 1'b1;
    for (int i = 0; i < N; i++) step(i == 0, 1'b1, 12'hFFF, 3'b000, 1'b1);
    drain(D + 2);
    pat = 1'b0;
    check("pattern_x3_y2", seen.size() > 2*W+3 ? seen[2*W+3].data : 12'h000, 12'h320);
`endif

    // Randomized frames: sparse pixels, random ready and kernel, occasional truncation.
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < $urandom_range(0, 5); k++)
        step(1'b0, $urandom_range(0, 1), 12'($urandom_range(0, 4095)), 3'($urandom), $urandom_range(0, 1));
      budget = 0;
      fs = 1'b1;
      while ((fs || m_in_frame) && budget < 4 * N) begin
        step(fs, $urandom_range(0, 9) < 7, 12'($urandom_range(0, 4095)),
             3'($urandom), $urandom_range(0, 9) < 6);
        fs = m_in_frame && ($urandom_range(0, 299) == 0);
        budget++;
      end
    end
    drain(D + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_packetizer.md
VIDEO_PACKETIZER -- requirements
Module: video_packetizer

Interface
REQ-001 Parameter IMG_WIDTH, default 320, SHALL set the active pixels per line.
REQ-002 Parameter IMG_LENGTH, default 240, SHALL set the active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the output buffer entries; it is a power of two, minimum 2.
REQ-004 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 frame_start  input  1  SHALL be a one-cycle pulse marking the start of a camera frame.
REQ-007 pixel_valid  input  1  SHALL qualify pixel_data; the camera cannot be stalled.
REQ-008 pixel_data  input  12  SHALL carry the RGB444 camera pixel.
REQ-009 freq_flag_in  input  3  SHALL carry the requested edge-kernel selection.
REQ-010 ready_in  input  1  SHALL be the downstream (edge_filter) ready.
REQ-011 valid_out, startofpacket_out, endofpacket_out  output  1 each  SHALL be the Avalon-ST packet controls.
REQ-012 data_out  output  12  SHALL carry the pixel beat.
REQ-013 freq_flag_out  output  3  SHALL carry the frame-stable kernel selection.
REQ-014 overflow  output  1  SHALL be a sticky per-frame error flag.

Function
REQ-015 The FSM SHALL have three states:
- IDLE: ignore pixels until frame_start.
- ACTIVE: pack pixels.
- DONE: discard pixels until frame_start.
REQ-016 frame_start SHALL, from any state:
- move the FSM to ACTIVE;
- clear the x/y counters to 0;
- clear overflow;
- latch freq_flag_in into a pending register.
REQ-017 In ACTIVE, each pixel_valid cycle SHALL:
- write {pixel_data, sop=(x==0&&y==0), eop=(x==IMG_WIDTH-1&&y==IMG_LENGTH-1)} into the FIFO;
- advance x, wrapping at IMG_WIDTH-1 and incrementing y.
REQ-018 After the eop pixel is written, the FSM SHALL enter DONE.
REQ-019 When frame_start and pixel_valid occur in the same cycle, the pixel SHALL be treated as (0,0) with sop=1.
REQ-020 A frame_start arriving in ACTIVE SHALL truncate the current packet without emitting eop, and the next beat SHALL carry sop.
REQ-021 A write while the FIFO is full and no read occurs in that cycle SHALL drop the pixel, still advance x/y, and set overflow until the next frame_start or reset.
REQ-022 A write SHALL succeed when the FIFO is full and a read occurs in the same cycle.
REQ-023 valid_out SHALL equal FIFO non-empty, and a beat SHALL transfer when valid_out && ready_in.
REQ-024 data_out and valid_out SHALL be held stable while valid_out && !ready_in.
REQ-025 Latency SHALL be 1 cycle: a pixel written at edge N with the FIFO empty appears on data_out after edge N.
REQ-026 freq_flag_out SHALL load the pending value on the cycle the sop beat transfers, and SHALL be constant for the rest of the packet.
REQ-027 The x counter SHALL be $clog2(IMG_WIDTH) bits and the y counter $clog2(IMG_LENGTH) bits; comparisons SHALL use full width, with no wrap beyond the limits.

Reset
REQ-028 Reset SHALL immediately set:
- FSM to IDLE;
- x and y to 0;
- FIFO empty;
- valid_out, startofpacket_out, endofpacket_out and overflow to 0;
- data_out to 12'h000;
- freq_flag_out and the pending register to 3'b000.
REQ-029 Reset asserted mid-frame SHALL discard all buffered beats, and output SHALL resume only after a frame_start following deassertion.

Configuration
REQ-030 With VIDEO_PACKETIZER_PATTERN_EN defined:
- a 1-bit input pattern_sel SHALL exist;
- when pattern_sel=1, the written data SHALL be {x[3:0], y[3:0], 4'h0} in place of pixel_data;
- timing SHALL be unchanged.
REQ-031 Without VIDEO_PACKETIZER_PATTERN_EN, pattern_sel and the pattern logic SHALL be absent, and pixel_data SHALL always be used.

Structure
REQ-032 The shared package video_pkg SHALL hold:
- IMG_WIDTH_DEF and IMG_LENGTH_DEF;
- typedef pixel_t (logic [11:0]);
- typedef beat_t (struct of pixel_t data, sop, eop);
- typedef kernel_sel_t (logic [2:0]).
REQ-033 The FIFO SHALL be a separate sub-module, stream_fifo, parameterised by depth and beat_t, providing full/empty and same-cycle read/write.

Verification
REQ-034 Reset, then frame_start and 76800 consecutive pixels with ready_in=1 -> exactly 76800 beats; sop on beat 0 only; eop on beat 76799 only; data matches input in order.
REQ-035 Full frame with ready_in held 0 for cycles 10..20 (FIFO_DEPTH=4) -> overflow=1 from the first dropped pixel; beats after the gap still carry correct (x,y)-derived eop at count 76800 input pixels.
REQ-036 freq_flag_in=3'b010 at frame_start, changed to 3'b001 mid-frame -> freq_flag_out=3'b010 for the whole packet, and 3'b001 only after the next frame's sop transfer.
REQ-037 frame_start after 100 pixels -> the 101st pixel is emitted with sop=1, and no eop is emitted for the truncated packet.
REQ-038 Extra 5 pixels after eop, followed by reset asserted asynchronously mid-beat -> the extra pixels are not emitted; after reset all outputs are 0 and valid_out=0.
REQ-039 With VIDEO_PACKETIZER_PATTERN_EN, pattern_sel=1 -> beat at x=3, y=2 equals 12'h320.
